// File: rtl/uart_tx_frame_if.sv
// Word handshake between the TX FIFO and the UART transmitter, plus the line-break request.
// The master drives the word and break request; tx_ready comes back from the transmitter.
interface uart_tx_frame_if #(
  parameter int DBIT = 8
);
  logic            tx_valid;
  logic [DBIT-1:0] tx_data;
  logic            tx_ready;
  logic            break_req;

  modport master (
    output tx_valid,
    output tx_data,
    output break_req,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    input  break_req,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: start/data/optional parity/stop framing plus line-break generation.
// tx falls one clk after a word is accepted; tx_ready stays low for the whole frame or break.
module uart_tx_frame #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16,
  parameter int PARITY     = 0,
  parameter int BRK_BITS   = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  uart_tx_frame_if.slave   bus,
  output logic             tx,
  output logic             tx_done_tick,
  output logic             busy
);

  localparam int S_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int SW    = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int BW    = $clog2(BRK_BITS + 1);

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);
  localparam logic [BW-1:0] BRK_MIN     = BW'(BRK_BITS);
  localparam logic [BW-1:0] BRK_LAST    = BW'(BRK_BITS - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;
  localparam logic [2:0] BREAK = 3'd5;

  logic [2:0]      state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [BW-1:0]   brk_cnt;
  logic [DBIT-1:0] shreg;
  logic            par_bit;
  logic            data_frame;
  logic            accept;
  logic            bit_end;

  // Gated by reset so the FIFO never pops a word the transmitter is about to drop.
  assign bus.tx_ready = (state == IDLE) && !bus.break_req && !reset;
  assign accept       = bus.tx_valid && bus.tx_ready;
  assign bit_end      = tick && (s == S_BIT_LAST);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      brk_cnt      <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      data_frame   <= 1'b0;
      tx           <= 1'b1;
      tx_done_tick <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          s <= '0;
          if (bus.break_req) begin
            state      <= BREAK;
            brk_cnt    <= '0;
            data_frame <= 1'b0;
            tx         <= 1'b0;
          end else if (accept) begin
            shreg      <= bus.tx_data;
            par_bit    <= (^bus.tx_data) ^ (PARITY == 2);
            data_frame <= 1'b1;
            state      <= START;
            tx         <= 1'b0;
          end
        end

        START: begin
          if (tick) begin
            if (bit_end) begin
              s     <= '0;
              n     <= '0;
              state <= DATA;
              tx    <= shreg[0];
            end else begin
              s <= s + SW'(1);
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (bit_end) begin
              s     <= '0;
              shreg <= {1'b0, shreg[DBIT-1:1]};
              if (n == N_LAST) begin
                if (PARITY != 0) begin
                  state <= PAR;
                  tx    <= par_bit;
                end else begin
                  state <= STOP;
                  tx    <= 1'b1;
                end
              end else begin
                n  <= n + NW'(1);
                tx <= shreg[1];
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end

        PAR: begin
          if (tick) begin
            if (bit_end) begin
              s     <= '0;
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              s <= s + SW'(1);
            end
          end
        end

        STOP: begin
          if (tick) begin
            if (s == S_STOP_LAST) begin
              s            <= '0;
              state        <= IDLE;
              tx_done_tick <= data_frame;
            end else begin
              s <= s + SW'(1);
            end
          end
        end

        BREAK: begin
          // Release is only considered on bit-period boundaries, so the break is whole periods long.
          if (tick) begin
            if (bit_end) begin
              s <= '0;
              if ((brk_cnt >= BRK_LAST) && !bus.break_req) begin
                state <= STOP;
                tx    <= 1'b1;
              end else if (brk_cnt < BRK_MIN) begin
                brk_cnt <= brk_cnt + BW'(1);
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
          s     <= '0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Drives four transmitter configurations and compares every cycle against a tick-count reference model.
module tb_uart_tx_frame;
  localparam int OS = 16;
  localparam int NU = 4;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       tick  = 1'b0;
  logic [3:0] valid = '0;
  logic [3:0] brk   = '0;
  logic [8:0] dat [NU];
  wire  [3:0] rdy, txl, done, bsy;

  int checks = 0;
  int errors = 0;
  int tmode  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  uart_tx_frame_if #(.DBIT(8)) if0 ();
  uart_tx_frame_if #(.DBIT(8)) if1 ();
  uart_tx_frame_if #(.DBIT(8)) if2 ();
  uart_tx_frame_if #(.DBIT(7)) if3 ();

  assign if0.tx_valid = valid[0]; assign if0.tx_data = dat[0][7:0]; assign if0.break_req = brk[0]; assign rdy[0] = if0.tx_ready;
  assign if1.tx_valid = valid[1]; assign if1.tx_data = dat[1][7:0]; assign if1.break_req = brk[1]; assign rdy[1] = if1.tx_ready;
  assign if2.tx_valid = valid[2]; assign if2.tx_data = dat[2][7:0]; assign if2.break_req = brk[2]; assign rdy[2] = if2.tx_ready;
  assign if3.tx_valid = valid[3]; assign if3.tx_data = dat[3][6:0]; assign if3.break_req = brk[3]; assign rdy[3] = if3.tx_ready;

  uart_tx_frame u0 (.clk(clk), .reset(rst), .tick(tick), .bus(if0), .tx(txl[0]), .tx_done_tick(done[0]), .busy(bsy[0]));
  uart_tx_frame #(.PARITY(1)) u1 (.clk(clk), .reset(rst), .tick(tick), .bus(if1), .tx(txl[1]), .tx_done_tick(done[1]), .busy(bsy[1]));
  uart_tx_frame #(.PARITY(2)) u2 (.clk(clk), .reset(rst), .tick(tick), .bus(if2), .tx(txl[2]), .tx_done_tick(done[2]), .busy(bsy[2]));
  uart_tx_frame #(.DBIT(7), .SB_TICK(32), .BRK_BITS(4)) u3 (.clk(clk), .reset(rst), .tick(tick), .bus(if3), .tx(txl[3]), .tx_done_tick(done[3]), .busy(bsy[3]));

  // Reference model: per unit, what the line is doing and how many ticks it has spent doing it.
  int m_dbit [NU] = '{8, 8, 8, 7};
  int m_par  [NU] = '{0, 1, 2, 0};
  int m_sb   [NU] = '{16, 16, 16, 32};
  int m_brk  [NU] = '{13, 13, 13, 4};

  int          mode  [NU];   // 0 idle, 1 frame, 2 break, 3 mark after break
  int          t     [NU];
  bit          pend  [NU];
  logic [11:0] fb    [NU];   // frame bits: start, data LSB first, optional parity
  int          nb    [NU];
  int          fin   [NU];
  int          dcnt  [NU];
  bit          acc   [NU];
  logic        ldone [NU];

  function automatic logic [3:0] expect_of(int u);
    logic e_tx;
    case (mode[u])
      0:       return {1'b1, pend[u], 1'b0, (!brk[u] && !rst)};
      1: begin
        e_tx = (t[u] < OS * nb[u]) ? fb[u][t[u] / OS] : 1'b1;
        return {e_tx, 1'b0, 1'b1, 1'b0};
      end
      2:       return 4'b0010;
      default: return 4'b1010;
    endcase
  endfunction

  task automatic model_step(int u);
    logic [8:0] d;
    acc[u] = 1'b0;
    if (rst) begin
      mode[u] = 0; t[u] = 0; pend[u] = 1'b0;
    end else begin
      case (mode[u])
        0: begin
          pend[u] = 1'b0;
          if (brk[u]) begin
            mode[u] = 2; t[u] = 0;
          end else if (valid[u]) begin
            d = dat[u] & 9'((1 << m_dbit[u]) - 1);
            fb[u] = '0;
            for (int i = 0; i < m_dbit[u]; i++) fb[u][i+1] = d[i];
            nb[u] = 1 + m_dbit[u];
            if (m_par[u] != 0) begin
              fb[u][nb[u]] = (^d) ^ (m_par[u] == 2);
              nb[u]++;
            end
            mode[u] = 1; t[u] = 0; acc[u] = 1'b1;
          end
        end
        1: if (tick) begin
          t[u]++;
          if (t[u] == OS * nb[u] + m_sb[u]) begin
            mode[u] = 0; pend[u] = 1'b1; fin[u]++;
          end
        end
        2: if (tick) begin
          t[u]++;
          if ((t[u] % OS == 0) && (t[u] / OS >= m_brk[u]) && !brk[u]) begin
            mode[u] = 3; t[u] = 0;
          end
        end
        default: if (tick) begin
          t[u]++;
          if (t[u] == m_sb[u]) mode[u] = 0;
        end
      endcase
    end
  endtask

  // One clock: check outputs mid-cycle with this cycle's inputs, advance the model, then pick the next tick.
  task automatic cycle();
    logic [3:0] obs, exp;
    @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      if (chk_en && errors < 100) begin
        exp = expect_of(u);
        obs = {txl[u], done[u], bsy[u], rdy[u]};
        checks++;
        assert (obs === exp) else begin
          errors++;
          $error("FAIL line u%0d @%0t observed(tx,done,busy,ready)=%b expected=%b", u, $time, obs, exp);
        end
      end
      ldone[u] = done[u];
      if (done[u] === 1'b1) dcnt[u]++;
      model_step(u);
    end
    @(posedge clk);
    #1;
    case (tmode)
      0:       tick = ~tick;
      1:       tick = 1'($urandom_range(1, 0));
      default: tick = 1'b0;
    endcase
  endtask

  task automatic wait_accept(int u);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!acc[u] && n < 3000);
    checks++;
    assert (acc[u] === 1'b1) else begin
      errors++;
      $error("FAIL accept_timeout u%0d observed=%0b expected=1", u, acc[u]);
    end
  endtask

  task automatic send(int u, logic [8:0] d);
    valid[u] = 1'b1;
    dat[u]   = d;
    wait_accept(u);
    valid[u] = 1'b0;
  endtask

  task automatic wait_idle(int u);
    int n = 0;
    while ((mode[u] != 0 || pend[u]) && n < 8000) begin
      cycle();
      n++;
    end
    cycle();
    checks++;
    assert (mode[u] == 0) else begin
      errors++;
      $error("FAIL idle_timeout u%0d observed_mode=%0d expected=0", u, mode[u]);
    end
  endtask

  task automatic run_until_t(int u, int lim);
    int n = 0;
    while (t[u] < lim && n < 8000) begin
      cycle();
      n++;
    end
  endtask

  initial begin
    int u, r;
    for (int i = 0; i < NU; i++) begin
      dat[i] = '0; mode[i] = 0; t[i] = 0; pend[i] = 1'b0; fb[i] = '0;
      nb[i] = 0; fin[i] = 0; dcnt[i] = 0; acc[i] = 1'b0; ldone[i] = 1'b0;
    end

    rst = 1'b1;
    cycle();
    chk_en = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    repeat (3) cycle();

    // 8N1, tick every other clk
    tmode = 0;
    send(0, 9'h04C); wait_idle(0);
    // even parity, odd parity, even parity with all-zero data
    send(1, 9'h04C); wait_idle(1);
    send(2, 9'h04C); wait_idle(2);
    send(1, 9'h000); wait_idle(1);
    // 7 data bits, two stop periods
    send(3, 9'h055); wait_idle(3);

    // back-to-back: second word waits in tx_data while the first is on the line
    valid[0] = 1'b1; dat[0] = 9'h0A5;
    wait_accept(0);
    dat[0] = 9'h03C;
    wait_accept(0);
    checks++;
    assert (ldone[0] === 1'b1) else begin
      errors++;
      $error("FAIL b2b_accept_on_done observed=%b expected=1", ldone[0]);
    end
    valid[0] = 1'b0;
    wait_idle(0);

    // break: single-clk pulse gives the minimum length, long hold stretches it
    brk[0] = 1'b1; cycle(); brk[0] = 1'b0;
    wait_idle(0);
    brk[0] = 1'b1; cycle();
    run_until_t(0, 20 * OS);
    brk[0] = 1'b0;
    wait_idle(0);

    // reset in the middle of data bit 3, then a clean word
    send(0, 9'h0FF);
    run_until_t(0, 4 * OS + 3);
    rst = 1'b1; cycle(); rst = 1'b0;
    cycle();
    send(0, 9'h081); wait_idle(0);

    // randomized traffic over all configurations
    repeat (28) begin
      u     = int'($urandom_range(NU - 1, 0));
      tmode = int'($urandom_range(1, 0));
      r     = int'($urandom_range(9, 0));
      if (r == 0) begin
        brk[u] = 1'b1;
        repeat ($urandom_range(3, 1)) cycle();
        brk[u] = 1'b0;
      end else begin
        send(u, 9'($urandom_range(511, 0)));
        if (r == 1) begin
          // break_req during a frame must not disturb it
          brk[u] = 1'b1;
          repeat ($urandom_range(20, 5)) cycle();
          brk[u] = 1'b0;
        end else if (r == 2) begin
          tmode = 2;
          repeat (60) cycle();
          tmode = 1;
        end
      end
      wait_idle(u);
      repeat ($urandom_range(3, 0)) cycle();
    end

    for (int i = 0; i < NU; i++) begin
      checks++;
      assert (dcnt[i] === fin[i]) else begin
        errors++;
        $error("FAIL done_count u%0d observed=%0d expected=%0d", i, dcnt[i], fin[i]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
